// File: rtl/wordle_keyboard_nav_if.sv
// ----------------------------------------------------------------------------
// wordle_keyboard_nav_if
// Guess hand-off channel between the keyboard navigator and the game checker.
//   word        8*WORD_LEN  guess buffer, letter i at word[8*i +: 8], i=0 first
//   word_valid  1           guess complete and offered
//   word_ready  1           checker accepts the guess
// master: the keyboard navigator (drives word/word_valid)
// slave : the game checker (drives word_ready)
// ----------------------------------------------------------------------------
interface wordle_keyboard_nav_if #(
    parameter int WORD_LEN = 5
);
    logic [8*WORD_LEN-1:0] word;
    logic                  word_valid;
    logic                  word_ready;

    modport master (
        output word,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/wordle_keyboard_nav.sv
// ----------------------------------------------------------------------------
// wordle_keyboard_nav
// On-screen keyboard navigator and word-entry controller for Wordle.
// A cursor is moved over a NUM_ROWS x NUM_COLS key grid (last row holds
// LAST_ROW_COLS keys) by single-cycle U/D/L/R pulses; C selects the key under
// the cursor. Letters accumulate into a WORD_LEN-letter guess (BACKSPACE
// removes, ENTER submits) which is offered to the checker over gw.
//
// Ports
//   Clk, reset          clock (rising edge), asynchronous active-high reset
//   Start, Ack          leave idle / acknowledge game over
//   U, D, L, R, C       move / select pulses (priority U > D > L > R > C)
//   done                game over from the checker
//   q_I..q_Done         one-hot state flags
//   cursor_row/col      cursor position
//   curr_key            code of the key under the cursor (combinational)
//   letter_count        letters in the guess buffer
//   gw                  guess hand-off (word, word_valid, word_ready)
//
// Build option: define WORDLE_KBD_WRAP_EN for wrap-around navigation at grid
// edges; otherwise moves at edges saturate.
// ----------------------------------------------------------------------------
module wordle_keyboard_nav #(
    parameter int NUM_ROWS      = 3,
    parameter int NUM_COLS      = 10,
    parameter int LAST_ROW_COLS = 8,
    parameter int WORD_LEN      = 5
) (
    input  logic                          Clk,
    input  logic                          reset,
    input  logic                          Start,
    input  logic                          Ack,
    input  logic                          U,
    input  logic                          D,
    input  logic                          L,
    input  logic                          R,
    input  logic                          C,
    input  logic                          done,
    output logic                          q_I,
    output logic                          q_Run,
    output logic                          q_Submit,
    output logic                          q_Done,
    output logic [$clog2(NUM_ROWS)-1:0]   cursor_row,
    output logic [$clog2(NUM_COLS)-1:0]   cursor_col,
    output logic [7:0]                    curr_key,
    output logic [$clog2(WORD_LEN+1)-1:0] letter_count,
    wordle_keyboard_nav_if.master         gw
);

    localparam int RW = $clog2(NUM_ROWS);
    localparam int CW = $clog2(NUM_COLS);
    localparam int LW = $clog2(WORD_LEN + 1);

    localparam logic [RW-1:0] LAST_ROW     = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] COL_MAX      = CW'(NUM_COLS - 1);
    localparam logic [CW-1:0] LAST_COL_MAX = CW'(LAST_ROW_COLS - 1);
    localparam logic [LW-1:0] FULL         = LW'(WORD_LEN);

    localparam int KEY_ENTER = 26;
    localparam int KEY_BKSP  = 27;

    typedef enum logic [3:0] {
        QI      = 4'b1000,
        QRUN    = 4'b0100,
        QSUBMIT = 4'b0010,
        QDONE   = 4'b0001
    } state_t;

    state_t                  state;
    logic [8*WORD_LEN-1:0]   word_r;
    int                      key_idx;
    logic [CW-1:0]           row_col_max;

    function automatic logic [7:0] key_code(input int k);
        if (k < 26)
            return 8'h41 + 8'(k);
        else if (k == KEY_ENTER)
            return 8'h0D;
        else if (k == KEY_BKSP)
            return 8'h08;
        else
            return 8'h20;
    endfunction

    // Column limit applied when the cursor lands on the shorter last row.
    function automatic logic [CW-1:0] clamp_col(input logic [CW-1:0] c);
        return (c > LAST_COL_MAX) ? LAST_COL_MAX : c;
    endfunction

    always_comb begin
        key_idx     = int'(cursor_row) * NUM_COLS + int'(cursor_col);
        curr_key    = key_code(key_idx);
        row_col_max = (cursor_row == LAST_ROW) ? LAST_COL_MAX : COL_MAX;
    end

    assign q_I           = (state == QI);
    assign q_Run         = (state == QRUN);
    assign q_Submit      = (state == QSUBMIT);
    assign q_Done        = (state == QDONE);
    assign gw.word       = word_r;
    assign gw.word_valid = (state == QSUBMIT);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state        <= QI;
            cursor_row   <= '0;
            cursor_col   <= '0;
            letter_count <= '0;
            word_r       <= '0;
        end else begin
            case (state)
                QI: begin
                    cursor_row   <= '0;
                    cursor_col   <= '0;
                    letter_count <= '0;
                    word_r       <= '0;
                    if (Start)
                        state <= QRUN;
                end

                QRUN: begin
                    if (done) begin
                        state <= QDONE;
                    end else if (U) begin
                        if (cursor_row != '0) begin
                            cursor_row <= cursor_row - RW'(1);
                        end
`ifdef WORDLE_KBD_WRAP_EN
                        else begin
                            cursor_row <= LAST_ROW;
                            cursor_col <= clamp_col(cursor_col);
                        end
`endif
                    end else if (D) begin
                        if (cursor_row != LAST_ROW) begin
                            cursor_row <= cursor_row + RW'(1);
                            if (cursor_row + RW'(1) == LAST_ROW)
                                cursor_col <= clamp_col(cursor_col);
                        end
`ifdef WORDLE_KBD_WRAP_EN
                        else begin
                            cursor_row <= '0;
                        end
`endif
                    end else if (L) begin
                        if (cursor_col != '0) begin
                            cursor_col <= cursor_col - CW'(1);
                        end
`ifdef WORDLE_KBD_WRAP_EN
                        else begin
                            cursor_col <= row_col_max;
                        end
`endif
                    end else if (R) begin
                        if (cursor_col != row_col_max) begin
                            cursor_col <= cursor_col + CW'(1);
                        end
`ifdef WORDLE_KBD_WRAP_EN
                        else begin
                            cursor_col <= '0;
                        end
`endif
                    end else if (C) begin
                        if (key_idx < 26) begin
                            if (letter_count < FULL) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (LW'(i) == letter_count)
                                        word_r[8*i +: 8] <= curr_key;
                                letter_count <= letter_count + LW'(1);
                            end
                        end else if (key_idx == KEY_BKSP) begin
                            if (letter_count != '0) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (LW'(i) == letter_count - LW'(1))
                                        word_r[8*i +: 8] <= 8'h00;
                                letter_count <= letter_count - LW'(1);
                            end
                        end else if (key_idx == KEY_ENTER) begin
                            if (letter_count == FULL)
                                state <= QSUBMIT;
                        end
                        // Blank keys (index > 27) are inert.
                    end
                end

                QSUBMIT: begin
                    // Guess is frozen; only the checker's acceptance moves on.
                    if (gw.word_ready) begin
                        word_r       <= '0;
                        letter_count <= '0;
                        state        <= QRUN;
                    end
                end

                QDONE: begin
                    if (Ack) begin
                        state        <= QI;
                        cursor_row   <= '0;
                        cursor_col   <= '0;
                        letter_count <= '0;
                        word_r       <= '0;
                    end
                end

                default: state <= QI;
            endcase
        end
    end

endmodule

// File: tb/tb_wordle_keyboard_nav.sv
module tb_wordle_keyboard_nav;

    logic       Clk = 1'b0;
    logic       reset;
    logic       Start, Ack, U, D, L, R, C, done;
    logic       q_I, q_Run, q_Submit, q_Done;
    logic [1:0] cursor_row;
    logic [3:0] cursor_col;
    logic [7:0] curr_key;
    logic [2:0] letter_count;

    int vectors     = 0;
    int miscompares = 0;
    int cur_r       = 0;
    int cur_c       = 0;

    wordle_keyboard_nav_if #(.WORD_LEN(5)) gw ();

    wordle_keyboard_nav #(
        .NUM_ROWS(3), .NUM_COLS(10), .LAST_ROW_COLS(8), .WORD_LEN(5)
    ) dut (
        .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
        .U(U), .D(D), .L(L), .R(R), .C(C), .done(done),
        .q_I(q_I), .q_Run(q_Run), .q_Submit(q_Submit), .q_Done(q_Done),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .curr_key(curr_key), .letter_count(letter_count),
        .gw(gw)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cursor(input int r, input int c);
        check("cursor_row", 64'(cursor_row), 64'(r));
        check("cursor_col", 64'(cursor_col), 64'(c));
    endtask

    // Drive buttons for exactly one rising edge; returns at the following
    // falling edge where the result is observable.
    task automatic pulse(input logic u, input logic d, input logic l, input logic r, input logic c);
        @(negedge Clk);
        U = u; D = d; L = l; R = r; C = c;
        @(negedge Clk);
        U = 0; D = 0; L = 0; R = 0; C = 0;
    endtask

    // Walk to column 0, then to the target row, then right to the target
    // column; exact pulse counts so the path is valid with or without wrap.
    task automatic move_to(input int r, input int c);
        repeat (cur_c) pulse(0, 0, 1, 0, 0);
        while (cur_r < r) begin pulse(0, 1, 0, 0, 0); cur_r++; end
        while (cur_r > r) begin pulse(1, 0, 0, 0, 0); cur_r--; end
        repeat (c) pulse(0, 0, 0, 1, 0);
        cur_c = c;
        check_cursor(r, c);
    endtask

    task automatic select_key(input int r, input int c);
        move_to(r, c);
        pulse(0, 0, 0, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        Start = 0; Ack = 0; U = 0; D = 0; L = 0; R = 0; C = 0; done = 0;
        gw.word_ready = 1'b0;

        // Reset state
        @(negedge Clk);
        check("rst_q_I", 64'(q_I), 64'd1);
        check("rst_flags", 64'({q_Run, q_Submit, q_Done}), 64'd0);
        check_cursor(0, 0);
        check("rst_curr_key", 64'(curr_key), 64'h41);
        check("rst_count", 64'(letter_count), 64'd0);
        check("rst_word", 64'(gw.word), 64'd0);
        check("rst_valid", 64'(gw.word_valid), 64'd0);
        @(negedge Clk);
        reset = 1'b0;

        // Start
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        check("start_q_Run", 64'(q_Run), 64'd1);
        check_cursor(0, 0);
        check("start_key", 64'(curr_key), 64'h41);

        // Edge moves at (0,0)
        pulse(0, 0, 1, 0, 0);
`ifdef WORDLE_KBD_WRAP_EN
        check_cursor(0, 9);
        pulse(1, 0, 0, 0, 0);
        check_cursor(2, 7);
        pulse(0, 1, 0, 0, 0);
        check_cursor(0, 7);
        cur_r = 0; cur_c = 7;
        move_to(0, 0);
`else
        check_cursor(0, 0);
        pulse(1, 0, 0, 0, 0);
        check_cursor(0, 0);
`endif

        // R x3 -> 'D'
        repeat (3) pulse(0, 0, 0, 1, 0);
        cur_c = 3;
        check("r3_key", 64'(curr_key), 64'h44);

        // (1,9) then D -> clamp to (2,7) BACKSPACE; U keeps col
        move_to(1, 9);
        pulse(0, 1, 0, 0, 0);
        check_cursor(2, 7);
        check("clamp_key", 64'(curr_key), 64'h08);
        pulse(1, 0, 0, 0, 0);
        check_cursor(1, 7);
        cur_r = 1; cur_c = 7;

        // BACKSPACE at count 0 ignored
        select_key(2, 7);
        check("bksp0_count", 64'(letter_count), 64'd0);
        check("bksp0_word", 64'(gw.word), 64'd0);

        // C R A N, then ENTER with 4 letters ignored
        select_key(0, 2);
        select_key(1, 7);
        select_key(0, 0);
        select_key(1, 3);
        check("four_count", 64'(letter_count), 64'd4);
        check("four_word", 64'(gw.word), 64'h00_4E_41_52_43);
        select_key(2, 6);
        check("enter4_run", 64'(q_Run), 64'd1);
        check("enter4_valid", 64'(gw.word_valid), 64'd0);

        // E completes, 6th letter (Z) ignored
        select_key(0, 4);
        check("five_count", 64'(letter_count), 64'd5);
        check("five_word", 64'(gw.word), 64'h45_4E_41_52_43);
        select_key(2, 5);
        check("six_count", 64'(letter_count), 64'd5);
        check("six_word", 64'(gw.word), 64'h45_4E_41_52_43);

        // BACKSPACE clears the last slot, then E again
        select_key(2, 7);
        check("bksp_count", 64'(letter_count), 64'd4);
        check("bksp_word", 64'(gw.word), 64'h00_4E_41_52_43);
        select_key(0, 4);

        // ENTER -> QSUBMIT
        select_key(2, 6);
        check("submit_valid", 64'(gw.word_valid), 64'd1);
        check("submit_flag", 64'(q_Submit), 64'd1);
        check("submit_word", 64'(gw.word), 64'h45_4E_41_52_43);

        // Ready low: buttons and done ignored, guess frozen
        pulse(0, 0, 0, 1, 0);
        @(negedge Clk); done = 1'b1;
        @(negedge Clk); done = 1'b0;
        check("hold_valid", 64'(gw.word_valid), 64'd1);
        check("hold_submit", 64'(q_Submit), 64'd1);
        check("hold_word", 64'(gw.word), 64'h45_4E_41_52_43);
        check("hold_count", 64'(letter_count), 64'd5);
        check_cursor(2, 6);

        // Handshake
        gw.word_ready = 1'b1;
        @(negedge Clk);
        gw.word_ready = 1'b0;
        check("xfer_valid", 64'(gw.word_valid), 64'd0);
        check("xfer_run", 64'(q_Run), 64'd1);
        check("xfer_count", 64'(letter_count), 64'd0);
        check("xfer_word", 64'(gw.word), 64'd0);
        check_cursor(2, 6);

        // U+R+C together: only U acts
        pulse(1, 0, 0, 1, 1);
        check_cursor(1, 6);
        check("urc_count", 64'(letter_count), 64'd0);
        cur_r = 1; cur_c = 6;

        // done with R: only done acts
        @(negedge Clk); done = 1'b1; R = 1'b1;
        @(negedge Clk); done = 1'b0; R = 1'b0;
        check("done_flag", 64'(q_Done), 64'd1);
        check_cursor(1, 6);
        @(negedge Clk); Ack = 1'b1;
        @(negedge Clk); Ack = 1'b0;
        check("ack_q_I", 64'(q_I), 64'd1);
        @(negedge Clk);
        check_cursor(0, 0);
        check("idle_key", 64'(curr_key), 64'h41);
        cur_r = 0; cur_c = 0;

        // Reset during QSUBMIT
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        check("restart_run", 64'(q_Run), 64'd1);
        repeat (5) select_key(0, 0);
        check("aaaaa_word", 64'(gw.word), 64'h41_41_41_41_41);
        select_key(2, 6);
        check("rst2_pre_valid", 64'(gw.word_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst2_valid", 64'(gw.word_valid), 64'd0);
        check("rst2_q_I", 64'(q_I), 64'd1);
        check("rst2_flags", 64'({q_Run, q_Submit, q_Done}), 64'd0);
        check("rst2_count", 64'(letter_count), 64'd0);
        check("rst2_word", 64'(gw.word), 64'd0);
        check("rst2_key", 64'(curr_key), 64'h41);
        check_cursor(0, 0);
        @(negedge Clk);
        reset = 1'b0;
        @(negedge Clk);
        check("post_rst_q_I", 64'(q_I), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wordle_keyboard_nav.md
# wordle_keyboard_nav

Parametrised on-screen keyboard navigator and word-entry controller for the Wordle game, second generation of the keyboard block. It moves a cursor over a configurable grid of keys from single-cycle button pulses and exposes the key under the cursor as an 8-bit code. It also accumulates selected letters into a WORD_LEN-letter guess, with backspace and enter keys. A completed guess is handed to the game checker over a valid/ready handshake.

## Interface
- NUM_ROWS, 3, number of key rows (≥2)
- NUM_COLS, 10, keys per full row
- LAST_ROW_COLS, 8, keys in the last row (1..NUM_COLS)
- WORD_LEN, 5, letters per guess (≥1)

- Clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- Start  in  1  leave idle, begin a game
- Ack  in  1  acknowledge game over, return to idle
- U, D, L, R  in  1 each  cursor move pulses (one cycle per press, pre-debounced)
- C  in  1  select pulse for the key under the cursor
- done  in  1  game over from the checker
- q_I, q_Run, q_Submit, q_Done  out  1 each  one-hot state flags
- cursor_row  out  $clog2(NUM_ROWS)  cursor row
- cursor_col  out  $clog2(NUM_COLS)  cursor column
- curr_key  out  8  code of the key under the cursor
- letter_count  out  $clog2(WORD_LEN+1)  letters currently in the buffer
- word  out  8*WORD_LEN  guess buffer; letter i at word[8*i +: 8], i=0 first
- word_valid  out  1  guess complete and offered
- word_ready  in  1  checker accepts the guess

## Operation
- Key index k = row*NUM_COLS + col. Total keys = (NUM_ROWS-1)*NUM_COLS + LAST_ROW_COLS.
- Key codes:
  - k<26: 8'h41+k ('A'..'Z').
  - k==26: ENTER, 8'h0D.
  - k==27: BACKSPACE, 8'h08.
  - k>27: 8'h20 (blank, selection ignored).
  - curr_key is combinational from the cursor registers.
- States:
  - QI=4'b1000, QRUN=4'b0100, QSUBMIT=4'b0010, QDONE=4'b0001.
  - Any illegal encoding goes to QI.
- QI:
  - Start=1 → QRUN.
  - Clears cursor to (0,0), letter_count, and word.
- QRUN, done=1: → QDONE. All button inputs are ignored that cycle.
- QRUN, otherwise, only the highest-priority asserted button acts. Priority is U > D > L > R > C.
- U/D moves the row by ±1.
  - Entering the last row with col ≥ LAST_ROW_COLS clamps col to LAST_ROW_COLS-1.
  - Leaving the last row keeps col.
- L/R moves col by ±1 within the current row length: NUM_COLS, or LAST_ROW_COLS on the last row.
- At any edge, moves saturate (no change) unless WORDLE_KBD_WRAP_EN is defined.
- C on a letter:
  - If letter_count < WORD_LEN: word[8*letter_count +: 8] ← code, letter_count+1.
  - Otherwise ignored.
- C on BACKSPACE:
  - If letter_count > 0: letter_count-1, and that slot is cleared to 8'h00.
  - Otherwise ignored.
- C on ENTER:
  - If letter_count == WORD_LEN: → QSUBMIT.
  - Otherwise ignored.
- QSUBMIT:
  - word_valid=1. word and letter_count are frozen; all buttons and done are ignored.
  - On an edge with word_ready=1: word and letter_count clear, → QRUN. The cursor is unchanged.
- QDONE: Ack=1 → QI.

## Timing
- All outputs are registered except curr_key, which is combinational from the cursor registers.
- A button pulse takes effect on the rising edge where it is sampled. The new cursor, word and flags are visible in the following cycle.
- word_valid rises one cycle after the ENTER select edge.
- The handshake transfers on the first edge with word_valid && word_ready; word_valid is low in the next cycle.
- word_ready may be held high in advance. The transfer still happens no earlier than the first cycle of QSUBMIT.
- Reset values:
  - q_I=1, other state flags 0.
  - cursor (0,0), curr_key=8'h41.
  - letter_count=0, word=0, word_valid=0.
- Reset mid-operation (any state, including QSUBMIT) immediately forces the reset values. No guess is delivered.

## Configuration
- WORDLE_KBD_WRAP_EN defined, wrap-around navigation:
  - L at col 0 → last col of the row; R at the last col → col 0.
  - U at row 0 → row NUM_ROWS-1, with the last-row col clamp applied.
  - D at row NUM_ROWS-1 → row 0.
- WORDLE_KBD_WRAP_EN undefined: moves at edges saturate.

## Test plan
- Reset, then Start → q_Run=1, cursor (0,0), curr_key=8'h41. Pulse R ×3 → curr_key=8'h44 ('D').
- Cursor at (1,9), pulse D → cursor (2,7), curr_key=8'h08 (BACKSPACE, index 27).
- Select C,R,A,N,E, then ENTER → word=bytes 43,52,41,4E,45 (i=0 first), word_valid=1. Hold word_ready low 3 cycles, then high → letter_count=0, word=0, q_Run=1.
- ENTER with 4 letters → ignored. 6th letter → ignored. BACKSPACE at count 0 → ignored. U+R+C in one cycle → only U acts.
- Edge moves at (0,0): L and U → no change without the macro. With WORDLE_KBD_WRAP_EN: L → (0,9); then U → (2,7).
- done during QRUN → q_Done=1. Then Ack → q_I=1. Assert reset during QSUBMIT → word_valid=0 and all reset values immediately.
